// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receive engine for the Kabeta UART
//
// Reassembles asynchronous frames from the Rxd pad: start bit, 7/8 data bits
// LSB first, optional parity bit, 1 or 2 stop bits. Each completed frame
// produces one single-cycle status pulse for the register block.
//
// Ports:
//   Clock           in   I/O clock
//   Reset           in   asynchronous active-low reset
//   Enable          in   UART enable; low aborts any frame and forces IDLE
//   Rxd             in   asynchronous serial input, idle high
//   DataLenLimit    in   data bit count minus 1 (6 = 7 bits, 7 = 8 bits)
//   StopLenLimit    in   0 = 1 stop bit, 1 = 2 stop bits
//   ParityEn        in   parity bit present
//   ParityPolarity  in   0 = even parity, 1 = odd parity
//   BaudLimit       in   bit period in clocks minus 1
//   RxData          out  last received data, unused MSBs read 0
//   RxReady         out  1-cycle pulse for a good frame
//   RxParityErr     out  1-cycle pulse for a parity mismatch
//   RxFrameErr      out  1-cycle pulse when a stop bit was sampled low
//   RxBusy          out  a frame is in progress

module uart_receiver (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        Rxd,
    input  logic [2:0]  DataLenLimit,
    input  logic        StopLenLimit,
    input  logic        ParityEn,
    input  logic        ParityPolarity,
    input  logic [13:0] BaudLimit,
    output logic [7:0]  RxData,
    output logic        RxReady,
    output logic        RxParityErr,
    output logic        RxFrameErr,
    output logic        RxBusy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rxState_t;

    rxState_t    state, nextState;

    logic        rxSync1, rxSync2, rxPrev;
    logic        rxBit;
    logic        fallEdge;

    logic [13:0] baudCnt, nextBaudCnt;
    logic [2:0]  bitIdx, nextBitIdx;
    logic        stopIdx, nextStopIdx;
    logic [7:0]  dataReg, nextDataReg;
    logic        parityAcc, nextParityAcc;
    logic        parityErrFlag, nextParityErrFlag;
    logic        frameErrFlag, nextFrameErrFlag;
    logic        stopFrameErr;

    // Frame format snapshot taken at start detection
    logic [2:0]  fmtDataLen, nextFmtDataLen;
    logic        fmtStopLen, nextFmtStopLen;
    logic        fmtParityEn, nextFmtParityEn;
    logic        fmtParityPol, nextFmtParityPol;
    logic [13:0] fmtBaud, nextFmtBaud;

    logic [7:0]  nextRxData;
    logic        nextRxReady, nextRxParityErr, nextRxFrameErr, nextRxBusy;

    logic        baudHit, halfHit;

    assign rxBit    = rxSync2;
    // A line held low (break) never re-triggers: an edge needs a high first
    assign fallEdge = rxPrev & ~rxSync2;
    assign baudHit  = (baudCnt == fmtBaud);
    assign halfHit  = (baudCnt == (fmtBaud >> 1));
    assign stopFrameErr = frameErrFlag | ~rxBit;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rxSync1       <= 1'b1;
            rxSync2       <= 1'b1;
            rxPrev        <= 1'b1;
            state         <= IDLE;
            baudCnt       <= '0;
            bitIdx        <= '0;
            stopIdx       <= 1'b0;
            dataReg       <= '0;
            parityAcc     <= 1'b0;
            parityErrFlag <= 1'b0;
            frameErrFlag  <= 1'b0;
            fmtDataLen    <= 3'd7;
            fmtStopLen    <= 1'b0;
            fmtParityEn   <= 1'b0;
            fmtParityPol  <= 1'b0;
            fmtBaud       <= '0;
            RxData        <= '0;
            RxReady       <= 1'b0;
            RxParityErr   <= 1'b0;
            RxFrameErr    <= 1'b0;
            RxBusy        <= 1'b0;
        end else begin
            rxSync1       <= Rxd;
            rxSync2       <= rxSync1;
            rxPrev        <= rxSync2;
            state         <= nextState;
            baudCnt       <= nextBaudCnt;
            bitIdx        <= nextBitIdx;
            stopIdx       <= nextStopIdx;
            dataReg       <= nextDataReg;
            parityAcc     <= nextParityAcc;
            parityErrFlag <= nextParityErrFlag;
            frameErrFlag  <= nextFrameErrFlag;
            fmtDataLen    <= nextFmtDataLen;
            fmtStopLen    <= nextFmtStopLen;
            fmtParityEn   <= nextFmtParityEn;
            fmtParityPol  <= nextFmtParityPol;
            fmtBaud       <= nextFmtBaud;
            RxData        <= nextRxData;
            RxReady       <= nextRxReady;
            RxParityErr   <= nextRxParityErr;
            RxFrameErr    <= nextRxFrameErr;
            RxBusy        <= nextRxBusy;
        end
    end

    always_comb begin
        nextState         = state;
        nextBaudCnt       = baudCnt + 14'd1;
        nextBitIdx        = bitIdx;
        nextStopIdx       = stopIdx;
        nextDataReg       = dataReg;
        nextParityAcc     = parityAcc;
        nextParityErrFlag = parityErrFlag;
        nextFrameErrFlag  = frameErrFlag;
        nextFmtDataLen    = fmtDataLen;
        nextFmtStopLen    = fmtStopLen;
        nextFmtParityEn   = fmtParityEn;
        nextFmtParityPol  = fmtParityPol;
        nextFmtBaud       = fmtBaud;
        nextRxData        = RxData;
        nextRxReady       = 1'b0;
        nextRxParityErr   = 1'b0;
        nextRxFrameErr    = 1'b0;
        nextRxBusy        = RxBusy;

        case (state)
            IDLE: begin
                nextBaudCnt = '0;
                if (Enable && fallEdge) begin
                    nextState         = START;
                    nextRxBusy        = 1'b1;
                    nextFmtDataLen    = DataLenLimit;
                    nextFmtStopLen    = StopLenLimit;
                    nextFmtParityEn   = ParityEn;
                    nextFmtParityPol  = ParityPolarity;
                    nextFmtBaud       = BaudLimit;
                    nextBitIdx        = '0;
                    nextStopIdx       = 1'b0;
                    nextDataReg       = '0;
                    nextParityAcc     = 1'b0;
                    nextParityErrFlag = 1'b0;
                    nextFrameErrFlag  = 1'b0;
                end
            end

            START: begin
                // Mid start bit: a high line here was only a glitch
                if (halfHit) begin
                    nextBaudCnt = '0;
                    if (!rxBit) begin
                        nextState = DATA;
                    end else begin
                        nextState  = IDLE;
                        nextRxBusy = 1'b0;
                    end
                end
            end

            DATA: begin
                if (baudHit) begin
                    nextBaudCnt         = '0;
                    nextDataReg[bitIdx] = rxBit;
                    nextParityAcc       = parityAcc ^ rxBit;
                    if (bitIdx == fmtDataLen) begin
                        nextState = fmtParityEn ? PARITY : STOP;
                    end else begin
                        nextBitIdx = bitIdx + 3'd1;
                    end
                end
            end

            PARITY: begin
                if (baudHit) begin
                    nextBaudCnt       = '0;
                    nextParityErrFlag = parityAcc ^ rxBit ^ fmtParityPol;
                    nextState         = STOP;
                end
            end

            STOP: begin
                if (baudHit) begin
                    nextBaudCnt      = '0;
                    nextFrameErrFlag = stopFrameErr;
                    if (stopIdx == fmtStopLen) begin
                        // Status is registered here so it is visible during DONE
                        nextState       = DONE;
                        nextRxData      = dataReg;
                        nextRxReady     = ~parityErrFlag & ~stopFrameErr;
                        nextRxParityErr = parityErrFlag;
                        nextRxFrameErr  = stopFrameErr;
                        nextRxBusy      = 1'b0;
                    end else begin
                        nextStopIdx = 1'b1;
                    end
                end
            end

            DONE: begin
                nextBaudCnt = '0;
                nextState   = IDLE;
            end

            default: begin
                nextBaudCnt = '0;
                nextState   = IDLE;
                nextRxBusy  = 1'b0;
            end
        endcase

        // Disable wins over everything, including a frame completing this cycle
        if (!Enable) begin
            nextState       = IDLE;
            nextBaudCnt     = '0;
            nextRxBusy      = 1'b0;
            nextRxReady     = 1'b0;
            nextRxParityErr = 1'b0;
            nextRxFrameErr  = 1'b0;
            nextRxData      = RxData;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver

module tb_uart_receiver;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Rxd;
    logic [2:0]  DataLenLimit;
    logic        StopLenLimit;
    logic        ParityEn;
    logic        ParityPolarity;
    logic [13:0] BaudLimit;
    logic [7:0]  RxData;
    logic        RxReady;
    logic        RxParityErr;
    logic        RxFrameErr;
    logic        RxBusy;

    int assertCount = 0;
    int failCount   = 0;

    int readyCnt = 0, parErrCnt = 0, frameErrCnt = 0, pulseWidthErr = 0;
    logic prevReady = 1'b0, prevPar = 1'b0, prevFrame = 1'b0;

    uart_receiver dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Enable         (Enable),
        .Rxd            (Rxd),
        .DataLenLimit   (DataLenLimit),
        .StopLenLimit   (StopLenLimit),
        .ParityEn       (ParityEn),
        .ParityPolarity (ParityPolarity),
        .BaudLimit      (BaudLimit),
        .RxData         (RxData),
        .RxReady        (RxReady),
        .RxParityErr    (RxParityErr),
        .RxFrameErr     (RxFrameErr),
        .RxBusy         (RxBusy)
    );

    always #5 Clock = ~Clock;

    // Pulse counters and width watch, sampled away from the active edge
    always @(negedge Clock) begin
        if (RxReady)     readyCnt++;
        if (RxParityErr) parErrCnt++;
        if (RxFrameErr)  frameErrCnt++;
        if ((RxReady && prevReady) || (RxParityErr && prevPar) || (RxFrameErr && prevFrame))
            pulseWidthErr++;
        prevReady = RxReady;
        prevPar   = RxParityErr;
        prevFrame = RxFrameErr;
    end

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic driveBit(input logic b, input int baud);
        Rxd = b;
        repeat (baud + 1) @(posedge Clock);
        #1;
    endtask

    task automatic idleBits(input int n, input int baud);
        for (int i = 0; i < n; i++) driveBit(1'b1, baud);
    endtask

    task automatic sendFrame(input logic [7:0] d, input int nBits, input bit hasPar, input bit parBit,
                             input int nStop, input bit s1, input bit s2, input int baud, input bit scramble);
        driveBit(1'b0, baud);
        if (scramble) begin
            DataLenLimit   = 3'($urandom);
            StopLenLimit   = 1'($urandom);
            ParityEn       = 1'($urandom);
            ParityPolarity = 1'($urandom);
            BaudLimit      = 14'($urandom_range(15, 300));
        end
        for (int i = 0; i < nBits; i++) driveBit(d[i], baud);
        if (hasPar) driveBit(parBit, baud);
        driveBit(s1, baud);
        if (nStop == 2) driveBit(s2, baud);
        Rxd = 1'b1;
    endtask

    // Reference: frame outcome from the format rules alone
    task automatic runFrame(input string tag, input logic [7:0] d, input int nBits, input bit hasPar,
                            input bit pol, input bit parBit, input int nStop, input bit s1, input bit s2,
                            input int baud, input bit scramble);
        logic [7:0] expData;
        int  ones, r0, p0, f0;
        bit  expPerr, expFerr, expReady;
        expData  = d & 8'((1 << nBits) - 1);
        ones     = $countones(expData);
        expPerr  = hasPar && (((ones + int'(parBit)) % 2) != int'(pol));
        expFerr  = !s1 || (nStop == 2 && !s2);
        expReady = !expPerr && !expFerr;

        DataLenLimit   = 3'(nBits - 1);
        StopLenLimit   = (nStop == 2);
        ParityEn       = hasPar;
        ParityPolarity = pol;
        BaudLimit      = 14'(baud);
        r0 = readyCnt; p0 = parErrCnt; f0 = frameErrCnt;
        sendFrame(d, nBits, hasPar, parBit, nStop, s1, s2, baud, scramble);
        checkValue({tag, "_ready"}, readyCnt - r0, int'(expReady));
        checkValue({tag, "_parerr"}, parErrCnt - p0, int'(expPerr));
        checkValue({tag, "_frameerr"}, frameErrCnt - f0, int'(expFerr));
        checkValue({tag, "_data"}, RxData, expData);
        checkValue({tag, "_busy"}, RxBusy, 0);
    endtask

    initial begin
        int r0, p0, f0;
        bit sawBusy;
        logic [7:0] held;

        Reset = 1'b0; Enable = 1'b1; Rxd = 1'b1;
        DataLenLimit = 3'd7; StopLenLimit = 1'b0; ParityEn = 1'b0; ParityPolarity = 1'b0;
        BaudLimit = 14'd129;
        repeat (3) @(negedge Clock);
        checkValue("reset_state", {RxData, RxReady, RxParityErr, RxFrameErr, RxBusy}, 0);
        Reset = 1'b1;
        repeat (5) @(posedge Clock);
        #1;
        checkValue("post_reset_idle", {RxData, RxBusy}, 0);

        // 8N1 basic
        runFrame("8n1_a5", 8'hA5, 8, 0, 0, 0, 1, 1, 1, 129, 0);

        // 8E1 good then bad parity
        idleBits(1, 129);
        runFrame("8e1_good", 8'h03, 8, 1, 0, 0, 1, 1, 1, 129, 0);
        idleBits(1, 129);
        runFrame("8e1_bad", 8'h03, 8, 1, 0, 1, 1, 1, 1, 129, 0);

        // 7O2 with second stop low, then good
        idleBits(1, 129);
        runFrame("7o2_stoplow", 8'h55, 7, 1, 1, 1, 2, 1, 0, 129, 0);
        idleBits(2, 129);
        runFrame("7o2_good", 8'h55, 7, 1, 1, 1, 2, 1, 1, 129, 0);

        // False start: 40-cycle glitch
        idleBits(1, 129);
        r0 = readyCnt; p0 = parErrCnt; f0 = frameErrCnt;
        sawBusy = 0;
        Rxd = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (RxBusy) sawBusy = 1;
        end
        @(posedge Clock); #1;
        Rxd = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge Clock);
            if (RxBusy) sawBusy = 1;
        end
        checkValue("falsestart_busy_rose", sawBusy, 1);
        checkValue("falsestart_busy_fell", RxBusy, 0);
        checkValue("falsestart_pulses", (readyCnt - r0) + (parErrCnt - p0) + (frameErrCnt - f0), 0);
        @(posedge Clock); #1;
        idleBits(1, 129);
        runFrame("after_false_3c", 8'h3C, 8, 0, 0, 0, 1, 1, 1, 129, 0);

        // Abort mid-DATA with Enable low
        idleBits(1, 129);
        held = RxData;
        r0 = readyCnt; p0 = parErrCnt; f0 = frameErrCnt;
        driveBit(1'b0, 129);
        driveBit(1'b1, 129);
        driveBit(1'b0, 129);
        checkValue("abort_busy_before", RxBusy, 1);
        Enable = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checkValue("abort_busy_next", RxBusy, 0);
        @(posedge Clock); #1;
        for (int i = 0; i < 6; i++) driveBit(1'($urandom), 129);
        driveBit(1'b1, 129);
        checkValue("abort_pulses", (readyCnt - r0) + (parErrCnt - p0) + (frameErrCnt - f0), 0);
        checkValue("abort_data_held", RxData, held);
        Enable = 1'b1;
        idleBits(1, 129);
        runFrame("reenable_81", 8'h81, 8, 0, 0, 0, 1, 1, 1, 129, 0);

        // Randomized frames, format inputs disturbed mid-frame
        for (int n = 0; n < 25; n++) begin
            int  nb, ns, bd;
            bit  hp, pl, pb, s1, s2;
            logic [7:0] d, m;
            nb = $urandom_range(7, 8);
            hp = 1'($urandom);
            pl = 1'($urandom);
            ns = $urandom_range(1, 2);
            bd = $urandom_range(15, 60);
            d  = 8'($urandom);
            m  = 8'((1 << nb) - 1);
            pb = (($countones(d & m) % 2) == int'(pl)) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            idleBits(2, bd);
            runFrame("rand", d, nb, hp, pl, pb, ns, s1, s2, bd, 1);
        end

        // Back-to-back 8N1 frames
        idleBits(2, 129);
        runFrame("b2b_12", 8'h12, 8, 0, 0, 0, 1, 1, 1, 129, 0);
        runFrame("b2b_34", 8'h34, 8, 0, 0, 0, 1, 1, 1, 129, 0);

        // Reset mid-frame
        idleBits(1, 129);
        driveBit(1'b0, 129);
        driveBit(1'b1, 129);
        checkValue("reset_mid_busy_before", RxBusy, 1);
        Reset = 1'b0;
        #1;
        checkValue("reset_mid_outputs", {RxData, RxReady, RxParityErr, RxFrameErr, RxBusy}, 0);
        Rxd = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (3) @(negedge Clock);

        checkValue("pulse_width", pulseWidthErr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive engine for the Kabeta UART peripheral. It oversamples the external `Rxd` pin on the I/O clock and reassembles asynchronous frames: start bit, 7 or 8 data bits LSB first, optional parity, and 1 or 2 stop bits. Each completed frame produces a single-cycle status pulse, which the UART register block uses to load DR and to set the SR/ISR bits. It sits between the `Rxd` pad and the UART register/interrupt logic, alongside the transmitter.

## Interface
- No parameters. Frame format comes from the UART control register.
- `Clock` in 1: I/O clock.
- `Reset` in 1: asynchronous, active-low reset.
- `Enable` in 1: UART enable (CR bit 0). Low forces IDLE.
- `Rxd` in 1: asynchronous serial input. Idle level is high.
- `DataLenLimit` in 3: data bit count minus 1. 6 means 7 bits, 7 means 8 bits.
- `StopLenLimit` in 1: 0 means 1 stop bit, 1 means 2 stop bits.
- `ParityEn` in 1: parity bit present.
- `ParityPolarity` in 1: 0 means even parity, 1 means odd parity.
- `BaudLimit` in 14: bit period in clocks minus 1.
- `RxData` out 8: last received data. Bits above the data length read 0.
- `RxReady` out 1: 1-cycle pulse for a good frame.
- `RxParityErr` out 1: 1-cycle pulse for a parity mismatch.
- `RxFrameErr` out 1: 1-cycle pulse when any stop bit is sampled low.
- `RxBusy` out 1: a frame is in progress.

## Operation
- **Synchronizer.** `Rxd` passes through a 2-FF synchronizer; both flops reset to 1. A falling edge is detected from the synchronized value and its 1-cycle delay.
- **Format capture.** On start detection, latch `DataLenLimit`, `StopLenLimit`, `ParityEn`, `ParityPolarity` and `BaudLimit`. Input changes mid-frame have no effect.
- **Baud counter.** 14-bit, cleared on every state entry.
- **States:**
  - IDLE: wait for a falling edge with `Enable`=1. Go to START and set `RxBusy`.
  - START: when counter = `BaudLimit>>1`, sample the line. Low goes to DATA with the counter cleared. High is a false start: go back to IDLE, drop `RxBusy`, emit no pulse.
  - DATA: sample when counter = `BaudLimit`. Shift bits in LSB first and XOR them into the parity accumulator. After bit index `DataLenLimit`, go to PARITY if `ParityEn`, else STOP.
  - PARITY: sample once. The error flag is set when data ^ parity bit ^ `ParityPolarity` ≠ 0.
  - STOP: sample `StopLenLimit`+1 stop bits. Any low sample sets the frame-error flag. After the last sample go to DONE.
  - DONE (1 cycle):
    - Load `RxData`; unused MSB = 0.
    - Pulse `RxReady` only if both error flags are clear.
    - Otherwise pulse `RxParityErr` and/or `RxFrameErr` (both may pulse together), with `RxReady`=0.
    - Clear `RxBusy`, then go to IDLE.
- **Enable low.** In any state, go to IDLE on the next clock. `RxBusy` drops, no pulse is emitted, and `RxData` holds its value.
- **Line held low after a frame error (break).** No re-trigger until the line has been seen high and then falls again.
- **RxData** changes only in DONE, including errored frames.

## Timing
- Reset values: `RxData`=0x00; `RxReady`, `RxParityErr`, `RxFrameErr`, `RxBusy` = 0. State = IDLE, sync flops = 1.
- Pin-to-edge-detect latency: 2 cycles. `RxBusy` rises 1 cycle after edge detect.
- Start check: (`BaudLimit`>>1)+1 cycles after START entry. Every later sample is exactly `BaudLimit`+1 cycles after the previous one.
- Status pulse: the cycle after the last stop-bit sample (mid-stop-bit). `RxBusy` falls in the same cycle.
- Earliest next start: the falling edge at the real end of the stop bit, so back-to-back frames are received.
- All outputs are registered; pulses are exactly 1 cycle wide.

## Test plan
- **8N1 basic.** `BaudLimit`=129, `DataLenLimit`=7, no parity, 1 stop. Drive 0xA5 at 130 clocks/bit. Required: one `RxReady` pulse, `RxData`=0xA5, no error pulses, `RxBusy` low afterwards.
- **8E1 good, then bad.** Send 0x03 with parity bit 0: `RxReady`. Send 0x03 with parity bit 1: one `RxParityErr` pulse, no `RxReady`, `RxData`=0x03.
- **7O2.** Send 0x55 with correct odd parity and the second stop bit low. Required: `RxFrameErr` pulse only, `RxData`=0x55. Repeat with the stop bit high: `RxReady`, `RxData`=0x55.
- **False start.** 40-cycle low glitch at `BaudLimit`=129. Required: `RxBusy` rises, then falls after the half-bit check; no pulses. A following valid 0x3C frame gives `RxReady`, `RxData`=0x3C.
- **Abort.** Drop `Enable` mid-DATA. Required: `RxBusy`=0 next cycle, no pulses, `RxData` unchanged. Re-enable and send 0x81: `RxReady`, `RxData`=0x81.
- **Back-to-back and reset.** Two consecutive 8N1 frames 0x12, 0x34 give two `RxReady` pulses. Assert `Reset` mid-frame: all outputs 0 immediately.
